// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: tag/value widths, entry layout {rob_id, value}, source ids.
package cdb_arbiter_pkg;

   localparam int CDB_ROB_WIDTH   = 4;
   localparam int CDB_VALUE_WIDTH = 32;
   localparam int CDB_NUM_SRC     = 2;

   // Source index doubles as the last_grant encoding; reset to SRC_LSB so ALU wins the first tie.
   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } cdb_src_e;

   function automatic cdb_src_e other_src(input cdb_src_e src);
      return (src == SRC_ALU) ? SRC_LSB : SRC_ALU;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result queue: circular buffer with wrapping pointers and an occupancy count.
module cdb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 36
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           en_in,
   input  logic                           clear_in,
   input  logic                           push_in,
   input  logic [WIDTH-1:0]               push_data_in,
   input  logic                           pop_in,
   output logic [WIDTH-1:0]               head_data_out,
   output logic                           empty_out,
   output logic [$clog2(DEPTH+1)-1:0]     count_out,
   output logic                           drop_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full      = (count_q == CW'(DEPTH));
   assign empty_out = (count_q == '0);
   assign count_out = count_q;

   assign do_push  = en_in && !clear_in && push_in && !full;
   assign do_pop   = en_in && !clear_in && pop_in && !empty_out;
   assign drop_out = en_in && !clear_in && push_in && full;

   assign head_data_out = mem_q[head_q];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (en_in) begin
         if (clear_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (do_push) tail_d = tail_q + PW'(1);
            if (do_pop)  head_d = head_q + PW'(1);
            case ({do_push, do_pop})
               2'b10:   count_d = count_q + CW'(1);
               2'b01:   count_d = count_q - CW'(1);
               default: count_d = count_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[tail_q] <= push_data_in;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LSB results, round-robin grants one per cycle onto a registered CDB.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int ROB_WIDTH = CDB_ROB_WIDTH,
   parameter int QDEPTH    = 2
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       rdy_in,
   input  logic                       clear,
   input  logic                       alu_valid,
   input  logic [ROB_WIDTH-1:0]       alu_rob_id,
   input  logic [CDB_VALUE_WIDTH-1:0] alu_value,
   input  logic                       lsb_valid,
   input  logic [ROB_WIDTH-1:0]       lsb_rob_id,
   input  logic [CDB_VALUE_WIDTH-1:0] lsb_value,
   output logic                       alu_full,
   output logic                       lsb_full,
   output logic                       cdb_ready,
   output logic [ROB_WIDTH-1:0]       cdb_rob_id,
   output logic [CDB_VALUE_WIDTH-1:0] cdb_value,
   output logic                       overflow
);

   localparam int EW = ROB_WIDTH + CDB_VALUE_WIDTH;
   localparam int CW = $clog2(QDEPTH + 1);

   logic [CDB_NUM_SRC-1:0] src_valid;
   logic [EW-1:0]          src_push_data [CDB_NUM_SRC];
   logic [EW-1:0]          src_head      [CDB_NUM_SRC];
   logic [CW-1:0]          src_count     [CDB_NUM_SRC];
   logic [CDB_NUM_SRC-1:0] src_empty;
   logic [CDB_NUM_SRC-1:0] src_full;
   logic [CDB_NUM_SRC-1:0] src_drop;
   logic [CDB_NUM_SRC-1:0] src_pop;

   logic                       grant_any;
   cdb_src_e                   grant_src;
   cdb_src_e                   last_grant_q, last_grant_d;
   logic                       cdb_ready_q, cdb_ready_d;
   logic [ROB_WIDTH-1:0]       cdb_rob_id_q, cdb_rob_id_d;
   logic [CDB_VALUE_WIDTH-1:0] cdb_value_q, cdb_value_d;
   logic                       overflow_q, overflow_d;

   assign src_valid     = {lsb_valid, alu_valid};
   assign src_push_data[0] = {alu_rob_id, alu_value};
   assign src_push_data[1] = {lsb_rob_id, lsb_value};

   genvar gi;
   generate
      for (gi = 0; gi < CDB_NUM_SRC; gi++) begin : g_src
         cdb_fifo #(
            .DEPTH (QDEPTH),
            .WIDTH (EW)
         ) u_fifo (
            .clk_in        (clk_in),
            .rst_in        (rst_in),
            .en_in         (rdy_in),
            .clear_in      (clear),
            .push_in       (src_valid[gi]),
            .push_data_in  (src_push_data[gi]),
            .pop_in        (src_pop[gi]),
            .head_data_out (src_head[gi]),
            .empty_out     (src_empty[gi]),
            .count_out     (src_count[gi]),
            .drop_out      (src_drop[gi])
         );
         assign src_full[gi] = (src_count[gi] == CW'(QDEPTH));
      end
   endgenerate

   assign alu_full = src_full[0];
   assign lsb_full = src_full[1];

   always_comb begin
      grant_any = 1'b0;
      grant_src = last_grant_q;
      if (rdy_in && !clear) begin
         if (!src_empty[0] && !src_empty[1]) begin
            grant_any = 1'b1;
            grant_src = other_src(last_grant_q);
         end else if (!src_empty[0]) begin
            grant_any = 1'b1;
            grant_src = SRC_ALU;
         end else if (!src_empty[1]) begin
            grant_any = 1'b1;
            grant_src = SRC_LSB;
         end
      end
   end

   always_comb begin
      src_pop = '0;
      if (grant_any) src_pop[grant_src] = 1'b1;
   end

   // Tag and value only move on a grant, so they hold their last broadcast otherwise.
   always_comb begin
      cdb_ready_d  = cdb_ready_q;
      cdb_rob_id_d = cdb_rob_id_q;
      cdb_value_d  = cdb_value_q;
      last_grant_d = last_grant_q;
      overflow_d   = overflow_q;
      if (rdy_in) begin
         cdb_ready_d = grant_any;
         overflow_d  = overflow_q | (|src_drop);
         if (grant_any) begin
            cdb_rob_id_d = src_head[grant_src][EW-1 -: ROB_WIDTH];
            cdb_value_d  = src_head[grant_src][CDB_VALUE_WIDTH-1:0];
            last_grant_d = grant_src;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cdb_ready_q  <= 1'b0;
         cdb_rob_id_q <= '0;
         cdb_value_q  <= '0;
         last_grant_q <= SRC_LSB;
         overflow_q   <= 1'b0;
      end else begin
         cdb_ready_q  <= cdb_ready_d;
         cdb_rob_id_q <= cdb_rob_id_d;
         cdb_value_q  <= cdb_value_d;
         last_grant_q <= last_grant_d;
         overflow_q   <= overflow_d;
      end
   end

   assign cdb_ready  = cdb_ready_q;
   assign cdb_rob_id = cdb_rob_id_q;
   assign cdb_value  = cdb_value_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin, full/overflow, clear, freeze and reset.
module tb_cdb_arbiter;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        clear;
   logic        alu_valid;
   logic [3:0]  alu_rob_id;
   logic [31:0] alu_value;
   logic        lsb_valid;
   logic [3:0]  lsb_rob_id;
   logic [31:0] lsb_value;
   logic        alu_full;
   logic        lsb_full;
   logic        cdb_ready;
   logic [3:0]  cdb_rob_id;
   logic [31:0] cdb_value;
   logic        overflow;

   int pass_cnt;
   int total_cnt;
   logic [3:0] bc_q [$];

   cdb_arbiter #(.ROB_WIDTH(4), .QDEPTH(2)) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rdy_in     (rdy_in),
      .clear      (clear),
      .alu_valid  (alu_valid),
      .alu_rob_id (alu_rob_id),
      .alu_value  (alu_value),
      .lsb_valid  (lsb_valid),
      .lsb_rob_id (lsb_rob_id),
      .lsb_value  (lsb_value),
      .alu_full   (alu_full),
      .lsb_full   (lsb_full),
      .cdb_ready  (cdb_ready),
      .cdb_rob_id (cdb_rob_id),
      .cdb_value  (cdb_value),
      .overflow   (overflow)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic idle();
      rdy_in     = 1'b1;
      clear      = 1'b0;
      alu_valid  = 1'b0;
      alu_rob_id = '0;
      alu_value  = '0;
      lsb_valid  = 1'b0;
      lsb_rob_id = '0;
      lsb_value  = '0;
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
      if (cdb_ready === 1'b1) begin
         bc_q.push_back(cdb_rob_id);
         $display("cdb broadcast rob=%0d value=0x%08h", cdb_rob_id, cdb_value);
      end
   endtask

   task automatic do_reset();
      idle();
      rst_in = 1'b0;
      #3;
      rst_in = 1'b1;
      bc_q.delete();
   endtask

   task automatic test_reset();
      idle();
      rst_in = 1'b0;
      #3;
      total_cnt++;
      if (cdb_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", cdb_ready); else pass_cnt++;
      total_cnt++;
      if (cdb_rob_id !== 4'd0) $display("FAIL reset_rob got=%0d want=0", cdb_rob_id); else pass_cnt++;
      total_cnt++;
      if (cdb_value !== 32'd0) $display("FAIL reset_value got=0x%08h want=0", cdb_value); else pass_cnt++;
      total_cnt++;
      if ({alu_full, lsb_full, overflow} !== 3'b000)
         $display("FAIL reset_flags got=%b want=000", {alu_full, lsb_full, overflow});
      else pass_cnt++;
      @(negedge clk_in);
      rst_in = 1'b1;
      step();
   endtask

   task automatic test_single();
      do_reset();
      alu_valid = 1'b1; alu_rob_id = 4'd3; alu_value = 32'h11;
      step();
      alu_valid = 1'b0;
      total_cnt++;
      if (cdb_ready !== 1'b0) $display("FAIL single_push_edge got=%b want=0", cdb_ready); else pass_cnt++;
      step();
      total_cnt++;
      if ({cdb_ready, cdb_rob_id, cdb_value} !== {1'b1, 4'd3, 32'h11})
         $display("FAIL single_bcast got=%b/%0d/0x%08h want=1/3/0x00000011", cdb_ready, cdb_rob_id, cdb_value);
      else pass_cnt++;
      step();
      total_cnt++;
      if (cdb_ready !== 1'b0) $display("FAIL single_after got=%b want=0", cdb_ready); else pass_cnt++;
   endtask

   task automatic test_dual();
      do_reset();
      alu_valid = 1'b1; alu_rob_id = 4'd1; alu_value = 32'hA1;
      lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'hB2;
      step();
      alu_valid = 1'b0; lsb_valid = 1'b0;
      step();
      total_cnt++;
      if ({cdb_ready, cdb_rob_id, cdb_value} !== {1'b1, 4'd1, 32'hA1})
         $display("FAIL dual_first got=%b/%0d/0x%08h want=1/1/0x000000a1", cdb_ready, cdb_rob_id, cdb_value);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({cdb_ready, cdb_rob_id, cdb_value} !== {1'b1, 4'd2, 32'hB2})
         $display("FAIL dual_second got=%b/%0d/0x%08h want=1/2/0x000000b2", cdb_ready, cdb_rob_id, cdb_value);
      else pass_cnt++;
      step();
      total_cnt++;
      if (cdb_ready !== 1'b0) $display("FAIL dual_after got=%b want=0", cdb_ready); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] a_id;
      logic [3:0] l_id;
      logic       saw_alu_full;
      logic       saw_lsb_full;
      logic [3:0] want;
      do_reset();
      a_id = 4'd0; l_id = 4'd8;
      saw_alu_full = 1'b0; saw_lsb_full = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (alu_full) saw_alu_full = 1'b1;
         if (lsb_full) saw_lsb_full = 1'b1;
         alu_valid = !alu_full; alu_rob_id = a_id; alu_value = 32'hA000_0000 | 32'(a_id);
         lsb_valid = !lsb_full; lsb_rob_id = l_id; lsb_value = 32'hB000_0000 | 32'(l_id);
         step();
         if (alu_valid) a_id = a_id + 4'd1;
         if (lsb_valid) l_id = l_id + 4'd1;
      end
      alu_valid = 1'b0; lsb_valid = 1'b0;
      for (int c = 0; c < 4; c++) step();
      total_cnt++;
      if (bc_q.size() != 8) $display("FAIL b2b_count got=%0d want=8", bc_q.size()); else pass_cnt++;
      for (int i = 0; i < 8 && i < bc_q.size(); i++) begin
         want = (i % 2 == 0) ? 4'(i / 2) : 4'(8 + i / 2);
         total_cnt++;
         if (bc_q[i] !== want) $display("FAIL b2b_order[%0d] got=%0d want=%0d", i, bc_q[i], want);
         else pass_cnt++;
      end
      total_cnt++;
      if ({saw_alu_full, saw_lsb_full} !== 2'b11)
         $display("FAIL b2b_full_seen got=%b want=11", {saw_alu_full, saw_lsb_full});
      else pass_cnt++;
      total_cnt++;
      if (overflow !== 1'b0) $display("FAIL b2b_overflow got=%b want=0", overflow); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [3:0] exp_seq [5];
      exp_seq = '{4'd4, 4'd9, 4'd5, 4'd10, 4'd6};
      do_reset();
      alu_valid = 1'b1; alu_rob_id = 4'd4;
      lsb_valid = 1'b1; lsb_rob_id = 4'd9;
      step();
      alu_rob_id = 4'd5; lsb_rob_id = 4'd10;
      step();
      alu_rob_id = 4'd6; lsb_valid = 1'b0;
      step();
      total_cnt++;
      if ({alu_full, overflow} !== 2'b10)
         $display("FAIL ovf_full got=%b want=10", {alu_full, overflow});
      else pass_cnt++;
      alu_rob_id = 4'd7;
      step();
      alu_valid = 1'b0;
      total_cnt++;
      if ({alu_full, overflow} !== 2'b01)
         $display("FAIL ovf_flag got=%b want=01", {alu_full, overflow});
      else pass_cnt++;
      for (int c = 0; c < 3; c++) step();
      total_cnt++;
      if (bc_q.size() != 5) $display("FAIL ovf_count got=%0d want=5", bc_q.size()); else pass_cnt++;
      for (int i = 0; i < 5 && i < bc_q.size(); i++) begin
         total_cnt++;
         if (bc_q[i] !== exp_seq[i]) $display("FAIL ovf_order[%0d] got=%0d want=%0d", i, bc_q[i], exp_seq[i]);
         else pass_cnt++;
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      step();
      total_cnt++;
      if (overflow !== 1'b1) $display("FAIL ovf_sticky_clear got=%b want=1", overflow); else pass_cnt++;
   endtask

   task automatic test_clear();
      do_reset();
      alu_valid = 1'b1; alu_rob_id = 4'd1;
      lsb_valid = 1'b1; lsb_rob_id = 4'd12;
      step();
      alu_valid = 1'b0; lsb_rob_id = 4'd13;
      step();
      total_cnt++;
      if (lsb_full !== 1'b1) $display("FAIL clr_prefull got=%b want=1", lsb_full); else pass_cnt++;
      clear = 1'b1;
      alu_valid = 1'b1; alu_rob_id = 4'd5;
      lsb_valid = 1'b1; lsb_rob_id = 4'd14;
      step();
      clear = 1'b0; alu_valid = 1'b0; lsb_valid = 1'b0;
      total_cnt++;
      if ({cdb_ready, lsb_full} !== 2'b00)
         $display("FAIL clr_next got=%b want=00", {cdb_ready, lsb_full});
      else pass_cnt++;
      bc_q.delete();
      for (int c = 0; c < 4; c++) step();
      total_cnt++;
      if (bc_q.size() != 0) $display("FAIL clr_stale got=%0d want=0", bc_q.size()); else pass_cnt++;
      total_cnt++;
      if (overflow !== 1'b0) $display("FAIL clr_overflow got=%b want=0", overflow); else pass_cnt++;
   endtask

   task automatic test_freeze_reset();
      do_reset();
      alu_valid = 1'b1; alu_rob_id = 4'd1;
      lsb_valid = 1'b1; lsb_rob_id = 4'd2;
      step();
      alu_valid = 1'b0; lsb_valid = 1'b0;
      step();
      rdy_in = 1'b0;
      alu_valid = 1'b1; alu_rob_id = 4'd7;
      for (int c = 0; c < 3; c++) begin
         step();
         total_cnt++;
         if ({cdb_ready, cdb_rob_id, alu_full} !== {1'b1, 4'd1, 1'b0})
            $display("FAIL frz_hold[%0d] got=%b/%0d/%b want=1/1/0", c, cdb_ready, cdb_rob_id, alu_full);
         else pass_cnt++;
      end
      rdy_in = 1'b1; alu_valid = 1'b0;
      step();
      total_cnt++;
      if ({cdb_ready, cdb_rob_id} !== {1'b1, 4'd2})
         $display("FAIL frz_resume got=%b/%0d want=1/2", cdb_ready, cdb_rob_id);
      else pass_cnt++;
      step();
      total_cnt++;
      if (cdb_ready !== 1'b0) $display("FAIL frz_no_push got=%b want=0", cdb_ready); else pass_cnt++;
      alu_valid = 1'b1; alu_rob_id = 4'd3;
      lsb_valid = 1'b1; lsb_rob_id = 4'd4;
      step();
      alu_valid = 1'b0; lsb_valid = 1'b0;
      step();
      #2;
      rst_in = 1'b0;
      #1;
      total_cnt++;
      if ({cdb_ready, cdb_rob_id, cdb_value} !== {1'b0, 4'd0, 32'd0})
         $display("FAIL rst_async got=%b/%0d/0x%08h want=0/0/0", cdb_ready, cdb_rob_id, cdb_value);
      else pass_cnt++;
      @(negedge clk_in);
      rst_in = 1'b1;
      bc_q.delete();
      for (int c = 0; c < 3; c++) step();
      total_cnt++;
      if (bc_q.size() != 0) $display("FAIL rst_drained got=%0d want=0", bc_q.size()); else pass_cnt++;
      total_cnt++;
      if ({alu_full, lsb_full, overflow} !== 3'b000)
         $display("FAIL rst_flags got=%b want=000", {alu_full, lsb_full, overflow});
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_single();
      test_dual();
      test_back_to_back();
      test_overflow();
      test_clear();
      test_freeze_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ROB_WIDTH, default `ROB_WIDTH, ROB tag width.
REQ-002 Parameter QDEPTH, default 2, per-source queue depth (power of two, >=2).
REQ-003 clk_in  input  1  sole clock; all state updates on posedge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  global ready; low freezes all state.
REQ-006 clear  input  1  mispredict flush.
REQ-007 alu_valid / alu_rob_id / alu_value  input  1 / ROB_WIDTH / 32  ALU result push.
REQ-008 lsb_valid / lsb_rob_id / lsb_value  input  1 / ROB_WIDTH / 32  LSB result push.
REQ-009 alu_full / lsb_full  output  1 / 1  queue at QDEPTH; producer holds off.
REQ-010 cdb_ready / cdb_rob_id / cdb_value  output  1 / ROB_WIDTH / 32  registered broadcast to RS, LSB, ROB.
REQ-011 overflow  output  1  sticky push-while-full error flag.

Function
REQ-012 Each source has a FIFO queue of QDEPTH entries {rob_id, value}, with head/tail pointers that wrap modulo QDEPTH and an occupancy count.
REQ-013 Push occurs when valid=1, rdy_in=1, clear=0 and the queue is not full; push while full is dropped and sets overflow.
REQ-014 xx_full = (count == QDEPTH), combinational from registered count only.
REQ-015 Each cycle with rdy_in=1 and clear=0, at most one non-empty queue is granted; the granted head is popped and registered onto cdb_* the next edge.
REQ-016 Grant is round-robin: a 1-bit last_grant register; both non-empty -> the source not granted last wins; one non-empty -> that source wins; last_grant updates only on a grant.
REQ-017 Latency: a push into an empty queue with no competitor appears on cdb_ready exactly 1 cycle after the push edge; no combinational input-to-cdb path.
REQ-018 cdb_ready is high for exactly one cycle per popped entry; it is 0 in any cycle with no grant.
REQ-019 Simultaneous push and pop on the same queue is legal at any count below QDEPTH; count is unchanged.
REQ-020 clear=1 with rdy_in=1: both queues are emptied, cdb_ready goes to 0 next edge, same-cycle pushes are discarded, last_grant is kept, overflow is kept.
REQ-021 rdy_in=0: no push, pop, grant, or flag update; cdb_* hold their values (cdb_ready is not re-issued after rdy_in rises unless a new grant occurs).
REQ-022 Entries from one source are broadcast in push order; no ordering is guaranteed across sources.
REQ-023 cdb_value and cdb_rob_id are don't-care when cdb_ready=0, but they hold their last values.

Reset
REQ-024 rst_in low asynchronously sets all counts and pointers to 0, cdb_ready=0, cdb_rob_id=0, cdb_value=0, last_grant=1 (first tie goes to ALU), and overflow=0.
REQ-025 Reset asserted mid-operation discards all queued entries; the first grant after release follows REQ-016 with last_grant=1.

Structure
REQ-026 ROB_WIDTH and the CDB entry layout {rob_id, value} come from the shared defines header; nothing is redefined locally.
REQ-027 A single sub-module, cdb_fifo (parameterised depth, push/pop, full/empty/count), is instantiated once per source; arbitration and output registers stay in cdb_arbiter.

Verification
REQ-028 Single ALU push rob=3, val=0x11 into empty queues -> cdb_ready=1, rob=3, val=0x11 next cycle; 0 after.
REQ-029 ALU rob=1 and LSB rob=2 pushed same cycle after reset -> broadcasts rob=1 then rob=2 on consecutive cycles.
REQ-030 Both sources push every cycle for 6 cycles -> broadcasts strictly alternate ALU/LSB; the full flags assert and are honoured; overflow stays 0.
REQ-031 Fill ALU queue to 2 and force a third push -> alu_full=1, overflow=1, the dropped entry never appears on the CDB.
REQ-032 Queue 2 LSB entries, pulse clear -> cdb_ready=0 next cycle; no stale rob_id is broadcast afterwards; lsb_full=0.
REQ-033 rdy_in low for 3 cycles with pending entries, and rst_in pulsed mid-drain -> state frozen while rdy_in is low; after reset all outputs are 0 and queues are empty.
